// File: rtl/mul_ctrl_if.sv
// Execute-stage / iterative-multiplier handshake bundle for mul_ctrl.
// slave is the controller side, master is the pipeline+multiplier side.
interface mul_ctrl_if;
    logic        valid_i;
    logic [1:0]  funct_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        stall_o;
    logic        start_o;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [1:0]  mul_opcode_o;
    logic [63:0] prod_i;
    logic        ready_i;
    logic [31:0] result_o;
    logic        result_valid_o;

    modport slave (
        input  valid_i, funct_i, rs1_i, rs2_i, flush_i, prod_i, ready_i,
        output stall_o, start_o, op1_o, op2_o, mul_opcode_o, result_o, result_valid_o
    );

    modport master (
        output valid_i, funct_i, rs1_i, rs2_i, flush_i, prod_i, ready_i,
        input  stall_o, start_o, op1_o, op2_o, mul_opcode_o, result_o, result_valid_o
    );
endinterface

// File: rtl/mul_ctrl.sv
// RV32M multiply sequencer: converts signed operands to magnitudes, drives an
// unsigned iterative multiplier, and re-applies the sign to the 64-bit product.
module mul_ctrl (
    input  logic      clk,
    input  logic      rst,
    mul_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t      state;
    logic [1:0]  funct_q;
    logic        neg_q;
    logic        start_q;
    logic        rvalid_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic [31:0] result_q;

    logic        sgn1;
    logic        sgn2;
    logic        neg1;
    logic        neg2;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        zero_op;
    logic        accept;
    logic [63:0] prod_adj;
    logic [31:0] res_sel;

    // MULH: both signed; MULHSU: rs1 only; MUL/MULHU: neither
    always_comb begin
        sgn1    = (bus.funct_i == 2'b01) || (bus.funct_i == 2'b10);
        sgn2    = (bus.funct_i == 2'b01);
        neg1    = sgn1 & bus.rs1_i[31];
        neg2    = sgn2 & bus.rs2_i[31];
        mag1    = neg1 ? (~bus.rs1_i + 32'd1) : bus.rs1_i;
        mag2    = neg2 ? (~bus.rs2_i + 32'd1) : bus.rs2_i;
        zero_op = (bus.rs1_i == 32'd0) || (bus.rs2_i == 32'd0);
        accept  = bus.valid_i && !bus.flush_i;
    end

    always_comb begin
        prod_adj = neg_q ? (~bus.prod_i + 64'd1) : bus.prod_i;
        res_sel  = (funct_q == 2'b00) ? prod_adj[31:0] : prod_adj[63:32];
    end

    // A flush releases the pipeline in the same cycle it kills the multiply.
    always_comb begin
        bus.stall_o = !bus.flush_i &&
                      (((state == IDLE) && bus.valid_i) || (state == START) || (state == WAIT));
    end

    assign bus.start_o        = start_q;
    assign bus.op1_o          = op1_q;
    assign bus.op2_o          = op2_q;
    assign bus.result_o       = result_q;
    assign bus.result_valid_o = rvalid_q;
    assign bus.mul_opcode_o   = 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            funct_q  <= 2'b00;
            neg_q    <= 1'b0;
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    start_q  <= 1'b0;
                    rvalid_q <= 1'b0;
                    if (accept) begin
                        funct_q <= bus.funct_i;
                        neg_q   <= neg1 ^ neg2;
                        op1_q   <= mag1;
                        op2_q   <= mag2;
                        if (zero_op) begin
                            // product is known to be zero; skip the multiplier
                            result_q <= 32'd0;
                            rvalid_q <= 1'b1;
                            state    <= DONE;
                        end else begin
                            start_q <= 1'b1;
                            state   <= START;
                        end
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state   <= bus.flush_i ? IDLE : WAIT;
                end
                WAIT: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else if (bus.ready_i) begin
                        result_q <= res_sel;
                        rvalid_q <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    rvalid_q <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_ctrl.sv
// Randomized scoreboard bench for mul_ctrl; the bench also plays the multiplier.
module tb_mul_ctrl;
    logic clk;
    logic rst;
    mul_ctrl_if bus();

    mul_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural result straight from the ISA definition using 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            2'b00:   p = ua * ub;
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] absval(input logic [31:0] x, input bit is_signed);
        if (is_signed && x[31]) return 32'd0 - x;
        return x;
    endfunction

    always @(negedge clk) begin
        if (bus.result_valid_o) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got strobe with result %h, expected none at %0t",
                         bus.result_o, $time);
            end else begin
                chk("result", {32'd0, bus.result_o}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int dly, input bit flsh, input bit rdy_start);
        logic [31:0] m1, m2;
        m1 = absval(a, (f == 2'b01) || (f == 2'b10));
        m2 = absval(b, (f == 2'b01));
        bus.valid_i = 1'b1;
        bus.funct_i = f;
        bus.rs1_i   = a;
        bus.rs2_i   = b;
        #1 chk("stall_idle_valid", {63'd0, bus.stall_o}, 64'd1);
        if (a == 32'd0 || b == 32'd0) begin
            exp_q.push_back(ref_res(f, a, b));
            @(negedge clk);
            bus.valid_i = 1'b0;
            #1;
            chk("zero_no_start", {63'd0, bus.start_o}, 64'd0);
            chk("zero_valid_t1", {63'd0, bus.result_valid_o}, 64'd1);
            chk("zero_stall_done", {63'd0, bus.stall_o}, 64'd0);
            @(negedge clk);
            return;
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
        #1;
        chk("start_pulse", {63'd0, bus.start_o}, 64'd1);
        chk("op1", {32'd0, bus.op1_o}, {32'd0, m1});
        chk("op2", {32'd0, bus.op2_o}, {32'd0, m2});
        chk("opcode", {62'd0, bus.mul_opcode_o}, 64'd0);
        chk("stall_start", {63'd0, bus.stall_o}, 64'd1);
        if (rdy_start) begin
            bus.ready_i = 1'b1;
            bus.prod_i  = {$urandom, $urandom};
        end
        @(negedge clk);
        bus.ready_i = 1'b0;
        chk("start_one_cycle", {63'd0, bus.start_o}, 64'd0);
        chk("no_early_valid", {63'd0, bus.result_valid_o}, 64'd0);
        repeat (dly) @(negedge clk);
        chk("op1_stable", {32'd0, bus.op1_o}, {32'd0, m1});
        if (flsh) begin
            bus.flush_i = 1'b1;
            @(negedge clk);
            bus.flush_i = 1'b0;
            #1 chk("stall_after_flush", {63'd0, bus.stall_o}, 64'd0);
            repeat (2) @(negedge clk);
            bus.ready_i = 1'b1;
            bus.prod_i  = {32'd0, m1} * {32'd0, m2};
            @(negedge clk);
            bus.ready_i = 1'b0;
            chk("stale_ready_ignored", {63'd0, bus.result_valid_o}, 64'd0);
            return;
        end
        bus.ready_i = 1'b1;
        bus.prod_i  = {32'd0, m1} * {32'd0, m2};
        exp_q.push_back(ref_res(f, a, b));
        @(negedge clk);
        bus.ready_i = 1'b0;
        chk("valid_r1", {63'd0, bus.result_valid_o}, 64'd1);
        #1 chk("stall_done", {63'd0, bus.stall_o}, 64'd0);
        @(negedge clk);
        chk("valid_one_cycle", {63'd0, bus.result_valid_o}, 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        bus.funct_i = 2'b00;
        bus.rs1_i   = 32'd0;
        bus.rs2_i   = 32'd0;
        bus.flush_i = 1'b0;
        bus.prod_i  = 64'd0;
        bus.ready_i = 1'b0;
        @(negedge clk);
        chk("rst_start", {63'd0, bus.start_o}, 64'd0);
        chk("rst_valid", {63'd0, bus.result_valid_o}, 64'd0);
        chk("rst_result", {32'd0, bus.result_o}, 64'd0);
        chk("rst_op1", {32'd0, bus.op1_o}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'd7, 32'd6, 2, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 1'b1);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'd2, 1, 1'b0, 1'b0);
        run_op(2'b00, 32'd0, 32'h1234, 0, 1'b0, 1'b0);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1, 1'b0, 1'b0);
        run_op(2'b00, 32'd9, 32'd9, 1, 1'b1, 1'b0);

        // valid together with flush in IDLE accepts nothing
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.funct_i = 2'b00;
        bus.rs1_i   = 32'd3;
        bus.rs2_i   = 32'd0;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        chk("flush_idle_no_start", {63'd0, bus.start_o}, 64'd0);
        chk("flush_idle_no_valid", {63'd0, bus.result_valid_o}, 64'd0);

        // reset in WAIT abandons the operation
        bus.valid_i = 1'b1;
        bus.funct_i = 2'b01;
        bus.rs1_i   = 32'hFFFF_FFFD;
        bus.rs2_i   = 32'd5;
        @(negedge clk);
        bus.valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_op1", {32'd0, bus.op1_o}, 64'd0);
        chk("rst_mid_op2", {32'd0, bus.op2_o}, 64'd0);
        chk("rst_mid_stall", {63'd0, bus.stall_o}, 64'd0);
        chk("rst_mid_result", {32'd0, bus.result_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.ready_i = 1'b1;
        bus.prod_i  = 64'd15;
        @(negedge clk);
        bus.ready_i = 1'b0;
        chk("post_rst_idle", {63'd0, bus.start_o | bus.result_valid_o}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(),
                   $urandom_range(0, 5), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-003: valid_i  input  1  execute stage presents an M-extension multiply instruction.
REQ-004: funct_i  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-005: rs1_i, rs2_i  input  32 each  source operands as read from the register file.
REQ-006: flush_i  input  1  pipeline flush; kills the in-flight multiply.
REQ-007: stall_o  output  1  holds the upstream pipeline while a multiply is pending.
REQ-008: start_o  output  1  single-cycle start pulse to the iterative multiplier (its startE).
REQ-009: op1_o, op2_o  output  32 each  unsigned operand magnitudes to the multiplier.
REQ-010: mul_opcode_o  output  2  multiplier opcode; constant 2'b00 (full 64-bit product mode).
REQ-011: prod_i  input  64  unsigned 64-bit product returned by the multiplier.
REQ-012: ready_i  input  1  multiplier completion; prod_i valid in the same cycle.
REQ-013: result_o  output  32  final rd write-back value, registered.
REQ-014: result_valid_o  output  1  one-cycle strobe qualifying result_o.

Function
REQ-015: FSM states SHALL be IDLE, START, WAIT, DONE.
REQ-016: IDLE with valid_i=1 and flush_i=0 SHALL latch funct_i, sign flag and operand magnitudes; next state START, or DONE if rs1_i or rs2_i is zero.
REQ-017: Signedness: MUL and MULHU treat both operands unsigned; MULH both signed; MULHSU rs1 signed, rs2 unsigned.
REQ-018: Magnitude of a signed negative operand SHALL be its 32-bit two's complement (0x80000000 maps to 0x80000000); neg flag = XOR of the signs of signed operands.
REQ-019: op1_o/op2_o SHALL be registered magnitudes, stable from START until the state leaves WAIT.
REQ-020: START SHALL assert start_o for exactly one cycle, then go to WAIT; ready_i in START is ignored.
REQ-021: WAIT SHALL hold until ready_i=1; then result = neg ? (~prod_i + 1) : prod_i (64-bit), result_o gets bits [31:0] for MUL, [63:32] otherwise; next state DONE.
REQ-022: Zero-operand path SHALL set result_o to 0 and never assert start_o.
REQ-023: DONE SHALL assert result_valid_o for one cycle, then return to IDLE; a new instruction is accepted only in IDLE.
REQ-024: stall_o SHALL be combinational: high in IDLE when valid_i=1, high in START and WAIT, low in DONE.
REQ-025: Latency: accept in cycle T -> start_o in T+1; ready_i in cycle R -> result_valid_o in R+1; zero path -> result_valid_o in T+1.
REQ-026: flush_i=1 in START or WAIT SHALL force IDLE next cycle, suppress result_valid_o, and drop stall_o.
REQ-027: flush_i=1 in DONE SHALL NOT cancel the strobe; flush_i and valid_i both high in IDLE SHALL accept nothing.
REQ-028: ready_i asserted in IDLE or DONE (stale completion after flush) SHALL be ignored.

Reset
REQ-029: rst=0 SHALL asynchronously force IDLE and clear start_o, result_valid_o, result_o, op1_o, op2_o, neg flag and latched funct.
REQ-030: Reset asserted mid-operation SHALL abandon the operation; after release the block accepts only a fresh valid_i.

Verification
REQ-031: MUL 7 x 6 -> one start_o pulse, op1_o=7, op2_o=6; prod_i=42 with ready_i -> result_o=0x0000002A, result_valid_o one cycle later.
REQ-032: MULH 0xFFFFFFFF x 0x00000002 -> op1_o=1, op2_o=2; prod_i=2 -> result_o=0xFFFFFFFF.
REQ-033: MULHU 0xFFFFFFFF x 0xFFFFFFFF, prod_i=0xFFFFFFFE00000001 -> result_o=0xFFFFFFFE.
REQ-034: MULHSU 0x80000000 x 0x00000002 -> op1_o=0x80000000; prod_i=0x100000000 -> result_o=0xFFFFFFFF.
REQ-035: MUL 0 x 0x1234 -> no start_o, result_o=0, result_valid_o in T+1, stall_o low in that cycle.
REQ-036: flush_i in WAIT, then ready_i 3 cycles later -> no result_valid_o, state IDLE; rst=0 in WAIT -> all outputs 0 immediately.
